div_iter: RTL

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter_if.sv | 27 ++
 rtl/div_iter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/div_iter_if.sv
// div_iter_if -- request/response bundle for the iterative divider.
//   master: requester (execute stage / hazard unit side)
//     drives  in_valid, sign, srca, srcb, flush
//     samples out_valid, hi, lo
//   slave : div_iter
//     samples in_valid, sign, srca, srcb, flush
//     drives  out_valid, hi (remainder), lo (quotient)
interface div_iter_if;
  logic        in_valid;
  logic        sign;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        flush;
  logic        out_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output in_valid, sign, srca, srcb, flush,
    input  out_valid, hi, lo
  );

  modport slave (
    input  in_valid, sign, srca, srcb, flush,
    output out_valid, hi, lo
  );
endinterface

// File: rtl/div_iter.sv
// div_iter -- 32-bit iterative restoring divider (DIV / DIVU).
//   clk : rising-edge clock for all state
//   rst : asynchronous, active-high reset
//   bus : div_iter_if.slave
//         in_valid/sign/srca/srcb/flush in, out_valid/hi/lo out
//         (hi = remainder, lo = quotient)
// One request is accepted in IDLE, 32 BUSY cycles do one quotient bit each,
// and out_valid pulses for one cycle in DONE. All outputs come straight from
// registers, so there is no input-to-output combinational path.
module div_iter (
  input  logic      clk,
  input  logic      rst,
  div_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  count_reg;
  logic [63:0] rq_reg;        // {partial remainder, quotient}
  logic [31:0] divisor_reg;
  logic        q_neg_reg;
  logic        r_neg_reg;
  logic        dz_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        out_valid_reg;

  logic        accept;
  logic        last_step;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] partial;
  logic        ge;
  logic [31:0] rem_sub;
  logic [63:0] rq_step;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
  // right unsigned magnitude for the most negative value.
  always_comb begin
    mag_a = (bus.sign && bus.srca[31]) ? (~bus.srca + 32'd1) : bus.srca;
    mag_b = (bus.sign && bus.srcb[31]) ? (~bus.srcb + 32'd1) : bus.srcb;
  end

  // One restoring step. After the left shift the upper 33 bits of the
  // 65-bit value are rq_reg[63:31]; when the divisor fits, the difference is
  // below 2^32 so a 32-bit subtraction is exact.
  always_comb begin
    partial = rq_reg[63:31];
    ge      = (partial >= {1'b0, divisor_reg});
    rem_sub = partial[31:0] - divisor_reg;
    rq_step = ge ? {rem_sub, rq_reg[30:0], 1'b1}
                 : {partial[31:0], rq_reg[30:0], 1'b0};
  end

  // Sign fixup applied to the result of the final step.
  // A zero divisor leaves the dividend magnitude in the remainder and all
  // ones in the quotient; negating that remainder by the dividend's sign
  // rebuilds the original srca exactly, so hi needs no special case and only
  // lo is forced.
  always_comb begin
    q_fix = q_neg_reg ? (~rq_step[31:0] + 32'd1)  : rq_step[31:0];
    r_fix = r_neg_reg ? (~rq_step[63:32] + 32'd1) : rq_step[63:32];
  end

  // Next-state logic. flush overrides everything, including DONE.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last_step  = 1'b0;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            accept     = 1'b1;
            state_next = BUSY;
          end
        end
        BUSY: begin
          if (count_reg == 6'd31) begin
            last_step  = 1'b1;
            state_next = DONE;
          end
        end
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg     <= 6'd0;
      rq_reg        <= 64'd0;
      divisor_reg   <= 32'd0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      dz_reg        <= 1'b0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
      out_valid_reg <= 1'b0;
    end else begin
      // Registered one cycle ahead so out_valid is high exactly in DONE.
      out_valid_reg <= last_step;

      if (accept) begin
        count_reg   <= 6'd0;
        rq_reg      <= {32'd0, mag_a};
        divisor_reg <= mag_b;
        q_neg_reg   <= bus.sign & (bus.srca[31] ^ bus.srcb[31]);
        r_neg_reg   <= bus.sign & bus.srca[31];
        dz_reg      <= (bus.srcb == 32'd0);
      end else if (bus.flush) begin
        count_reg <= 6'd0;
      end else if (state_reg == BUSY) begin
        count_reg <= count_reg + 6'd1;
        rq_reg    <= rq_step;
      end

      if (last_step) begin
        lo_reg <= dz_reg ? 32'hFFFF_FFFF : q_fix;
        hi_reg <= r_fix;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.hi        = hi_reg;
  assign bus.lo        = lo_reg;

endmodule
